// File: rtl/pwm_pkg.sv
// Shared limits and helpers for the multi-channel PWM generator.
// Optional fade ramping in pwm_multi_ch is enabled by defining PWM_FADE_EN.
package pwm_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_WIDTH = 16;
    localparam int MAX_PRESCALE = 65535;

    typedef logic [MAX_WIDTH-1:0] duty_max_t;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        int r;
        if (n <= 2)
            r = 1;
        else
            r = $clog2(n);
        return r;
    endfunction

    // All-ones duty for a given resolution: the 100% (constant high) code.
    function automatic duty_max_t duty_full(input int width);
        duty_max_t v;
        v = '0;
        for (int b = 0; b < MAX_WIDTH; b++) begin
            if (b < width)
                v[b] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Shared prescaler and phase counter; boundary marks the last tick of a PWM period.
// Used by pwm_multi_ch in both the plain and PWM_FADE_EN builds.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 196
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick,
    output logic [WIDTH-1:0] phase,
    output logic             boundary
);

    localparam int               PRE_W    = clog2_min1(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] FULL     = WIDTH'(duty_full(WIDTH));

    logic [PRE_W-1:0] pre_cnt;

    // With PRESCALE=1 the terminal count is 0, so tick stays high every cycle.
    assign tick     = (pre_cnt == PRE_LAST);
    assign boundary = tick && (phase == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            phase   <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            phase   <= phase + WIDTH'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// NUM_CH-channel PWM with shadowed duty registers applied at period boundaries.
// Define PWM_FADE_EN to ramp active duty toward shadow by FADE_STEP per period.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 196,
    parameter int FADE_STEP = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [clog2_min1(NUM_CH)-1:0] wr_ch,
    input  logic [WIDTH-1:0]              wr_duty,
    input  logic [NUM_CH-1:0]             pol,
    output logic [NUM_CH-1:0]             pwm_out,
    output logic                          period_start,
    output logic                          busy
);

    localparam int               CH_W = clog2_min1(NUM_CH);
    localparam logic [WIDTH-1:0] FULL = WIDTH'(duty_full(WIDTH));

    if (NUM_CH < 1 || NUM_CH > MAX_CH || WIDTH < 4 || WIDTH > MAX_WIDTH ||
        PRESCALE < 1 || PRESCALE > MAX_PRESCALE || FADE_STEP < 0) begin : g_param_err
        $error("pwm_multi_ch: parameter out of range");
    end

`ifdef PWM_FADE_EN
    // A step larger than the full scale behaves like an immediate load.
    localparam int             STEP_I = (FADE_STEP > (1 << WIDTH)) ? (1 << WIDTH) : FADE_STEP;
    localparam logic [WIDTH:0] STEP   = (WIDTH+1)'(STEP_I);

    if (FADE_STEP < 1) begin : g_fade_err
        $error("pwm_multi_ch: FADE_STEP must be at least 1 when fading");
    end
`endif

    logic             tick_unused;
    logic [WIDTH-1:0] phase;
    logic             boundary;

    pwm_tick_gen #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick_unused),
        .phase    (phase),
        .boundary (boundary)
    );

    // Out-of-range channel indices are dropped here rather than aliasing.
    logic wr_ok;
    assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] diff;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] active;
        logic [WIDTH-1:0] active_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                shadow <= '0;
            else if (wr_ok && (wr_ch == CH_W'(i)))
                shadow <= wr_duty;
        end

`ifdef PWM_FADE_EN
        logic [WIDTH:0] up_sum;
        logic [WIDTH:0] dn_gap;

        // One extra bit keeps the overshoot test exact near full scale.
        always_comb begin
            up_sum     = {1'b0, active} + STEP;
            dn_gap     = {1'b0, active} - {1'b0, shadow};
            active_nxt = active;
            if (active < shadow) begin
                if (up_sum >= {1'b0, shadow})
                    active_nxt = shadow;
                else
                    active_nxt = up_sum[WIDTH-1:0];
            end else if (active > shadow) begin
                if (dn_gap <= STEP)
                    active_nxt = shadow;
                else
                    active_nxt = active - STEP[WIDTH-1:0];
            end
        end
`else
        assign active_nxt = shadow;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                active <= '0;
            else if (boundary)
                active <= active_nxt;
        end

        assign raw[i]  = (active == FULL) ? 1'b1 : (phase < active);
        assign diff[i] = (active != shadow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            pwm_out      <= raw ^ pol;
            period_start <= boundary;
            busy         <= |diff;
        end
    end

endmodule
